// File: rtl/seq_match_logger.sv
// Timestamp logger for a sequence-detector match pulse: each match cycle pushes the
// free-running timestamp into a FWFT circular queue, drained through a valid/ready port.
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     match,
  input  logic                     clr_ovf,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic pop, push, full, drop;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    full     = 1'b0;
    drop     = 1'b0;
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    full = (level_q == LW'(DEPTH));
    pop  = (level_q != '0) && rd_ready;
    // A full queue still accepts the event when the head leaves on the same edge.
    push = match && (!full || pop);
    drop = match && full && !pop;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    // A drop on the same edge as a clear request keeps the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once level
  // marks them valid, so clearing them would cost logic for no behavioural gain.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= ts_q;
  end

  assign rd_valid  = (level_q != '0);
  assign rd_ts     = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: default-parameter instance for queue behaviour,
// narrow instance (TS_W=4, CNT_W=3) for timestamp wrap and counter saturation.
module tb_seq_match_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, match, clr_ovf, rd_ready;
  logic       rd_valid, overflow;
  logic [15:0] rd_ts;
  logic [3:0]  level;
  logic [7:0]  match_cnt;

  logic       w_reset, w_match, w_clr_ovf, w_rd_ready;
  logic       w_rd_valid, w_overflow;
  logic [3:0] w_rd_ts;
  logic [3:0] w_level;
  logic [2:0] w_match_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  seq_match_logger dut (
    .clk(clk), .reset(reset), .match(match), .clr_ovf(clr_ovf), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_ts(rd_ts), .level(level), .match_cnt(match_cnt),
    .overflow(overflow)
  );

  seq_match_logger #(.TS_W(4), .DEPTH(8), .CNT_W(3)) dut_w (
    .clk(clk), .reset(w_reset), .match(w_match), .clr_ovf(w_clr_ovf),
    .rd_ready(w_rd_ready), .rd_valid(w_rd_valid), .rd_ts(w_rd_ts), .level(w_level),
    .match_cnt(w_match_cnt), .overflow(w_overflow)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] hist;
    logic [6:0] bits;
    int         drain_exp [8];
    int         wrap_exp  [9];

    reset = 1'b1; match = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b0;
    w_reset = 1'b1; w_match = 1'b0; w_clr_ovf = 1'b0; w_rd_ready = 1'b0;
    tick();
    tick();

    check("reset_rd_valid",  32'(rd_valid),  0);
    check("reset_level",     32'(level),     0);
    check("reset_match_cnt", 32'(match_cnt), 0);
    check("reset_overflow",  32'(overflow),  0);

    // Single event three cycles after release
    reset = 1'b0;
    tick(); tick(); tick();
    match = 1'b1;
    tick();
    match = 1'b0;
    check("single_rd_valid",  32'(rd_valid),  1);
    check("single_rd_ts",     32'(rd_ts),     3);
    check("single_level",     32'(level),     1);
    check("single_match_cnt", 32'(match_cnt), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("single_pop_rd_valid", 32'(rd_valid), 0);
    check("single_pop_level",    32'(level),    0);

    // Bit stream 1,0,0,1,0,0,1 through a 1001 detector with overlap
    do_reset();
    hist = 4'b0000;
    bits = 7'b1001001;
    for (int i = 6; i >= 0; i--) begin
      hist  = {hist[2:0], bits[i]};
      match = (hist == 4'b1001);
      tick();
    end
    match = 1'b0;
    check("det_level",     32'(level),     2);
    check("det_match_cnt", 32'(match_cnt), 2);
    check("det_overflow",  32'(overflow),  0);
    check("det_first_ts",  32'(rd_ts),     3);
    rd_ready = 1'b1;
    tick();
    check("det_second_ts", 32'(rd_ts),     6);
    tick();
    rd_ready = 1'b0;
    check("det_drained",   32'(rd_valid),  0);

    // Ten back-to-back events into an undrained queue, ts 0..9
    do_reset();
    match = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    match = 1'b0;
    check("ovf_level",     32'(level),     8);
    check("ovf_flag",      32'(overflow),  1);
    check("ovf_match_cnt", 32'(match_cnt), 10);
    check("ovf_head",      32'(rd_ts),     0);

    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf",       32'(overflow),  0);
    check("clr_head_hold", 32'(rd_ts),     0);

    clr_ovf = 1'b1;
    match   = 1'b1;
    tick();
    clr_ovf = 1'b0;
    match   = 1'b0;
    check("clr_vs_drop_ovf", 32'(overflow),  1);
    check("clr_vs_drop_cnt", 32'(match_cnt), 11);
    check("clr_vs_drop_lvl", 32'(level),     8);

    // Idle from ts 12 to ts 20, then push and pop together on a full queue
    for (int i = 0; i < 8; i++) tick();
    match    = 1'b1;
    rd_ready = 1'b1;
    tick();
    match    = 1'b0;
    rd_ready = 1'b0;
    check("full_pp_level", 32'(level),     8);
    check("full_pp_head",  32'(rd_ts),     1);
    check("full_pp_ovf",   32'(overflow),  1);
    check("full_pp_cnt",   32'(match_cnt), 12);

    drain_exp = '{1, 2, 3, 4, 5, 6, 7, 20};
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_ts_%0d", i), 32'(rd_ts), 32'(drain_exp[i]));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_rd_valid", 32'(rd_valid), 0);
    check("drain_level",    32'(level),    0);

    // Narrow instance: 9 events 5 cycles apart, drained continuously
    wrap_exp = '{0, 5, 10, 15, 4, 9, 14, 3, 8};
    w_reset    = 1'b0;
    w_rd_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      w_match = 1'b1;
      tick();
      w_match = 1'b0;
      check($sformatf("wrap_valid_%0d", k), 32'(w_rd_valid), 1);
      check($sformatf("wrap_ts_%0d", k), 32'(w_rd_ts), 32'(wrap_exp[k]));
      check($sformatf("wrap_cnt_%0d", k), 32'(w_match_cnt), (k < 7) ? 32'(k + 1) : 7);
      for (int j = 0; j < 4; j++) tick();
    end
    w_rd_ready = 1'b0;
    check("wrap_level_end", 32'(w_level),    0);
    check("wrap_ovf_end",   32'(w_overflow), 0);

    // Reset mid-operation with five entries queued and match high on the reset edge
    do_reset();
    match = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    match = 1'b0;
    check("mid_level_before", 32'(level), 5);
    reset = 1'b1;
    match = 1'b1;
    tick();
    reset = 1'b0;
    match = 1'b0;
    check("mid_rd_valid",  32'(rd_valid),  0);
    check("mid_level",     32'(level),     0);
    check("mid_match_cnt", 32'(match_cnt), 0);
    check("mid_overflow",  32'(overflow),  0);
    match = 1'b1;
    tick();
    match = 1'b0;
    check("mid_restart_ts",    32'(rd_ts),     0);
    check("mid_restart_level", 32'(level),     1);
    check("mid_restart_cnt",   32'(match_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
